// File: rtl/sort_pkg.sv
// Shared definitions for the four-entry bubble-sort sequencer and its compare-swap unit.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SORT   = 2'd1,
        STREAM = 2'd2
    } sortState_e;

    localparam int SORT_N      = 4;
    localparam int SORT_PASSES = 3;
    localparam int SORT_PAIRS  = 3;

endpackage

// File: rtl/compare_swap.sv
// Combinational compare-swap: lo/hi are the values destined for the lower/higher register index.
// Optional macro SORT_DESC_EN flips the swap condition so the sort runs in descending order.
module compare_swap #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swap
);

    // Strict comparison keeps equal values in place.
`ifdef SORT_DESC_EN
    assign swap = (a < b);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/sort_sequencer.sv
// Four-entry register file sequenced through a fixed 3-pass bubble sort, then streamed out in order.
// Optional macro SORT_DESC_EN (in compare_swap) selects descending order; timing is identical.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [1:0]        load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    output logic [1:0]        out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    sortState_e        state_q;
    logic [1:0]        passCnt_q;
    logic [1:0]        pairCnt_q;
    logic [2:0]        streamCnt_q;
    logic [DATA_W-1:0] regFile_q [SORT_N];

    logic              busy_q;
    logic              outValid_q;
    logic [1:0]        outIdx_q;
    logic [DATA_W-1:0] outData_q;
    logic              done_q;

    logic [1:0]        pairHi;
    logic [DATA_W-1:0] cmpLo_d;
    logic [DATA_W-1:0] cmpHi_d;
    logic              cmpSwap;

    assign pairHi = pairCnt_q + 2'd1;

    compare_swap #(.DATA_W(DATA_W)) u_cmp (
        .a    (regFile_q[pairCnt_q]),
        .b    (regFile_q[pairHi]),
        .lo   (cmpLo_d),
        .hi   (cmpHi_d),
        .swap (cmpSwap)
    );

    // STREAM spends one extra edge at count SORT_N to drop busy/valid, which guarantees
    // an idle cycle before a held start can launch the next job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            passCnt_q   <= '0;
            pairCnt_q   <= '0;
            streamCnt_q <= '0;
            busy_q      <= 1'b0;
            outValid_q  <= 1'b0;
            outIdx_q    <= '0;
            outData_q   <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < SORT_N; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q     <= 1'b0;
                    outValid_q <= 1'b0;
                    done_q     <= 1'b0;
                    if (load_en) begin
                        regFile_q[load_addr] <= load_data;
                    end
                    if (start) begin
                        state_q   <= SORT;
                        busy_q    <= 1'b1;
                        passCnt_q <= '0;
                        pairCnt_q <= '0;
                    end
                end
                SORT: begin
                    regFile_q[pairCnt_q] <= cmpLo_d;
                    regFile_q[pairHi]    <= cmpHi_d;
                    if (pairCnt_q == 2'(SORT_PAIRS - 1)) begin
                        pairCnt_q <= '0;
                        if (passCnt_q == 2'(SORT_PASSES - 1)) begin
                            state_q     <= STREAM;
                            streamCnt_q <= '0;
                        end else begin
                            passCnt_q <= passCnt_q + 2'd1;
                        end
                    end else begin
                        pairCnt_q <= pairCnt_q + 2'd1;
                    end
                end
                STREAM: begin
                    if (streamCnt_q == 3'(SORT_N)) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        outValid_q <= 1'b0;
                        done_q     <= 1'b0;
                    end else begin
                        outValid_q  <= 1'b1;
                        outIdx_q    <= streamCnt_q[1:0];
                        outData_q   <= regFile_q[streamCnt_q[1:0]];
                        done_q      <= (streamCnt_q == 3'(SORT_N - 1));
                        streamCnt_q <= streamCnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = outValid_q;
    assign out_idx   = outIdx_q;
    assign out_data  = outData_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed self-checking bench for sort_sequencer; expectations switch with SORT_DESC_EN.
module tb_sort_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [3:0] load_data = '0;
    logic       start = 1'b0;
    logic       busy;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] out_data;
    logic       done;

    int checks = 0;
    int fails  = 0;

    logic       capBusy  [0:16];
    logic       capValid [0:16];
    logic       capDone  [0:16];
    logic [1:0] capIdx   [0:16];
    logic [3:0] capData  [0:16];

    sort_sequencer #(.DATA_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic load_word(input logic [1:0] a, input logic [3:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Capture index k holds outputs sampled just after edge Ek (E0 samples start).
    task automatic run_job(input bit withLoad, input logic [1:0] la, input logic [3:0] ld, input int injectAt);
        start = 1'b1;
        if (withLoad) begin
            load_en = 1'b1; load_addr = la; load_data = ld;
        end
        @(posedge clk); #1;
        start = 1'b0; load_en = 1'b0;
        capBusy[0] = busy; capValid[0] = out_valid; capDone[0] = done;
        capIdx[0] = out_idx; capData[0] = out_data;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            capBusy[k] = busy; capValid[k] = out_valid; capDone[k] = done;
            capIdx[k] = out_idx; capData[k] = out_data;
            if (k == injectAt) begin
                load_en = 1'b1; load_addr = 2'd0; load_data = 4'd15; start = 1'b1;
            end else begin
                load_en = 1'b0; start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, out_valid, done});
        end
        checks++;
        if ({out_idx, out_data} !== 6'd0) begin
            fails++; $display("[TB] FAIL reset_data: got idx=%0d data=%0d expected 0/0", out_idx, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [3:0] e [4];
        logic expBusy, expValid, expDone;
`ifdef SORT_DESC_EN
        e = '{4'd9, 4'd7, 4'd3, 4'd1};
`else
        e = '{4'd1, 4'd3, 4'd7, 4'd9};
`endif
        load_word(2'd0, 4'd9); load_word(2'd1, 4'd3);
        load_word(2'd2, 4'd7); load_word(2'd3, 4'd1);
        run_job(1'b0, 2'd0, 4'd0, -1);
        for (int k = 0; k <= 15; k++) begin
            expBusy  = (k <= 13);
            expValid = (k >= 10 && k <= 13);
            expDone  = (k == 13);
            checks++;
            if (capBusy[k] !== expBusy) begin
                fails++; $display("[TB] FAIL basic_busy k=%0d: got %b expected %b", k, capBusy[k], expBusy);
            end
            checks++;
            if (capValid[k] !== expValid) begin
                fails++; $display("[TB] FAIL basic_valid k=%0d: got %b expected %b", k, capValid[k], expValid);
            end
            checks++;
            if (capDone[k] !== expDone) begin
                fails++; $display("[TB] FAIL basic_done k=%0d: got %b expected %b", k, capDone[k], expDone);
            end
            if (expValid) begin
                checks++;
                if (capIdx[k] !== 2'(k - 10)) begin
                    fails++; $display("[TB] FAIL basic_idx k=%0d: got %0d expected %0d", k, capIdx[k], k - 10);
                end
                checks++;
                if (capData[k] !== e[k - 10]) begin
                    fails++; $display("[TB] FAIL basic_data k=%0d: got %0d expected %0d", k, capData[k], e[k - 10]);
                end
            end
        end
    endtask

    task automatic test_duplicates_and_sorted();
        logic [3:0] e1 [4];
        logic [3:0] e2 [4];
`ifdef SORT_DESC_EN
        e1 = '{4'd5, 4'd5, 4'd5, 4'd2};
        e2 = '{4'd8, 4'd6, 4'd4, 4'd2};
`else
        e1 = '{4'd2, 4'd5, 4'd5, 4'd5};
        e2 = '{4'd2, 4'd4, 4'd6, 4'd8};
`endif
        load_word(2'd0, 4'd5); load_word(2'd1, 4'd5);
        load_word(2'd2, 4'd2); load_word(2'd3, 4'd5);
        run_job(1'b0, 2'd0, 4'd0, -1);
        for (int k = 10; k <= 13; k++) begin
            checks++;
            if (capValid[k] !== 1'b1 || capData[k] !== e1[k - 10]) begin
                fails++; $display("[TB] FAIL dup_data k=%0d: got v=%b d=%0d expected v=1 d=%0d", k, capValid[k], capData[k], e1[k - 10]);
            end
        end
        load_word(2'd0, 4'd2); load_word(2'd1, 4'd4);
        load_word(2'd2, 4'd6); load_word(2'd3, 4'd8);
        run_job(1'b0, 2'd0, 4'd0, -1);
        for (int k = 9; k <= 14; k++) begin
            checks++;
            if (capValid[k] !== (k >= 10 && k <= 13)) begin
                fails++; $display("[TB] FAIL sorted_valid k=%0d: got %b", k, capValid[k]);
            end
            if (k >= 10 && k <= 13) begin
                checks++;
                if (capData[k] !== e2[k - 10]) begin
                    fails++; $display("[TB] FAIL sorted_data k=%0d: got %0d expected %0d", k, capData[k], e2[k - 10]);
                end
            end
        end
        checks++;
        if (capDone[13] !== 1'b1 || capBusy[14] !== 1'b0) begin
            fails++; $display("[TB] FAIL sorted_end: got done=%b busy=%b expected 1/0", capDone[13], capBusy[14]);
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] e [4];
`ifdef SORT_DESC_EN
        e = '{4'd4, 4'd3, 4'd2, 4'd1};
`else
        e = '{4'd1, 4'd2, 4'd3, 4'd4};
`endif
        load_word(2'd0, 4'd4); load_word(2'd1, 4'd3);
        load_word(2'd2, 4'd2); load_word(2'd3, 4'd1);
        run_job(1'b0, 2'd0, 4'd0, 3);
        for (int k = 10; k <= 13; k++) begin
            checks++;
            if (capData[k] !== e[k - 10]) begin
                fails++; $display("[TB] FAIL ignore_data k=%0d: got %0d expected %0d", k, capData[k], e[k - 10]);
            end
        end
        checks++;
        if (capBusy[15] !== 1'b0 || capBusy[16] !== 1'b0) begin
            fails++; $display("[TB] FAIL ignore_queued_start: got busy15=%b busy16=%b expected 0/0", capBusy[15], capBusy[16]);
        end
        run_job(1'b0, 2'd0, 4'd0, -1);
        for (int k = 10; k <= 13; k++) begin
            checks++;
            if (capData[k] !== e[k - 10] || capIdx[k] !== 2'(k - 10)) begin
                fails++; $display("[TB] FAIL resort_data k=%0d: got idx=%0d d=%0d expected idx=%0d d=%0d", k, capIdx[k], capData[k], k - 10, e[k - 10]);
            end
        end
    endtask

    task automatic test_load_with_start();
        logic [3:0] e [4];
`ifdef SORT_DESC_EN
        e = '{4'd8, 4'd6, 4'd4, 4'd0};
`else
        e = '{4'd0, 4'd4, 4'd6, 4'd8};
`endif
        load_word(2'd0, 4'd8); load_word(2'd1, 4'd6);
        load_word(2'd2, 4'd4); load_word(2'd3, 4'd2);
        run_job(1'b1, 2'd3, 4'd0, -1);
        for (int k = 10; k <= 13; k++) begin
            checks++;
            if (capData[k] !== e[k - 10]) begin
                fails++; $display("[TB] FAIL loadstart_data k=%0d: got %0d expected %0d", k, capData[k], e[k - 10]);
            end
        end
    endtask

    task automatic test_reset_mid_sort();
        load_word(2'd0, 4'd9); load_word(2'd1, 4'd3);
        load_word(2'd2, 4'd7); load_word(2'd3, 4'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("[TB] FAIL midsort_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL async_reset: got busy=%b valid=%b expected 0/0", busy, out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(1'b0, 2'd0, 4'd0, -1);
        for (int k = 10; k <= 13; k++) begin
            checks++;
            if (capValid[k] !== 1'b1 || capData[k] !== 4'd0) begin
                fails++; $display("[TB] FAIL restart_data k=%0d: got v=%b d=%0d expected v=1 d=0", k, capValid[k], capData[k]);
            end
        end
    endtask

    initial begin
        $display("[TB] sort_sequencer directed bench");
        test_reset();
        test_basic();
        test_duplicates_and_sorted();
        test_busy_ignore();
        test_load_with_start();
        test_reset_mid_sort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Controller that owns a four-entry register file and a single compare-swap unit, and sequences a fixed bubble sort across them. It sits between the nibble entry logic (indexed writes plus an enable) and the serial display logic. It accepts writes while idle and, on a start request, runs a deterministic sort. It then streams the sorted values one per cycle with a valid strobe and a completion pulse.

## Interface
- `DATA_W`, default 4: width of each stored value.
- Entry count is fixed at 4 and is not a parameter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `load_en`  in  1  write strobe for the register file.
- `load_addr`  in  2  entry index to write.
- `load_data`  in  DATA_W  value to write.
- `start`  in  1  sort request, level-sampled.
- `busy`  out  1  high while sorting or streaming.
- `out_valid`  out  1  high when `out_data` carries a sorted element.
- `out_idx`  out  2  position of the current element in sorted order.
- `out_data`  out  DATA_W  sorted element.
- `done`  out  1  one-cycle pulse on the last streamed element.

## Operation
- FSM states are IDLE, SORT and STREAM.
- **IDLE**
  - If `load_en` is high, `reg[load_addr]` takes `load_data` at the clock edge.
  - If `start` is high, go to SORT and clear the pass and pair counters.
  - A load and a start in the same cycle: the write lands first and is included in the sort.
- **SORT**
  - Takes exactly 9 cycles: 3 passes, each comparing pairs (0,1), (1,2), (2,3) in that order, one pair per cycle.
  - There is no early exit.
  - The pair is swapped only when `reg[j] > reg[j+1]` (strict), so equal values never move.
  - Swapped values are written back into the register file.
  - After the 9th comparison, go to STREAM.
- **STREAM**
  - Takes 4 cycles.
  - `out_data = reg[i]` and `out_idx = i` for i = 0..3; `out_valid` is high throughout.
  - `done` is high together with `out_idx` = 3, then the FSM returns to IDLE.
- While `busy` is high, `load_en` and `start` are ignored. They are neither queued nor written.
- The register file keeps the sorted contents after completion. A later `start` with no new loads re-sorts the same values and produces the same output.
- Comparisons are unsigned at DATA_W bits; there is no widening.

## Timing
- Reset values:
  - `busy`, `out_valid`, `done` = 0.
  - `out_idx` = 0, `out_data` = 0.
  - All register-file entries = 0.
  - FSM in IDLE, counters = 0.
- All outputs are registered.
- Cycle numbering: edge E0 samples `start` in IDLE.
  - `busy` rises after E0.
  - Compares occur at edges E1..E9.
  - `out_valid` is high after edges E10..E13, with `out_idx` 0..3.
  - `done` and the last element appear after E13.
  - `busy` and `out_valid` fall after E14.
- Start-to-first-output latency is 10 cycles. Total occupancy is 14 cycles.
- `start` held high continuously: a new sort begins at the first IDLE edge after completion, so there is one idle cycle between jobs.
- Reset asserted mid-operation clears everything immediately (asynchronously); no partial output follows.

## Configuration
- Macro `SORT_DESC_EN`.
- Defined: swap condition becomes `reg[j] < reg[j+1]`, so the order is descending. Timing is unchanged.
- Undefined: ascending order, as described above.

## Structure
- Shared package `sort_pkg` holds:
  - State enum: IDLE, SORT, STREAM.
  - `SORT_N` = 4, `SORT_PASSES` = 3, `SORT_PAIRS` = 3.
- Sub-module `compare_swap`: combinational. It takes two DATA_W inputs and outputs `lo`, `hi` and a `swap` flag, and honours `SORT_DESC_EN`.
- The FSM, counters and register file live in `sort_sequencer`.

## Test plan
- Load 9,3,7,1 at addr 0..3, pulse `start` → after 10 cycles `out_data` is 1,3,7,9 on `out_idx` 0..3; `done` is high with 9; `busy` spans 14 cycles.
- Load 5,5,2,5, then start → 2,5,5,5; with 2,4,6,8 preloaded (already sorted) → 2,4,6,8 with identical timing.
- Load 4,3,2,1, start; at cycle 3 assert `load_en` with addr 0, data 15 → output 1,2,3,4. A second start with no loads → 1,2,3,4 again.
- In IDLE, the same cycle carries `load_en` (addr 3, data 0) and `start`, with 8,6,4,2 preloaded → output 0,4,6,8.
- Assert `rst_n` low at cycle 5 of a sort → `busy` and `out_valid` drop immediately; a restart after release yields 0,0,0,0.
- With `SORT_DESC_EN`: load 9,3,7,1 → 9,7,3,1, with the same 10-cycle latency.
